// File: rtl/adc_config_seq.sv
// Three-wire serial configuration controller for ADCs sharing clock/data lines.
// Runs an autonomous boot sequence, then hands the transfer path to the host.
module adc_config_seq #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CLK_DIV_LOG2 = 7,
  parameter int unsigned BOOT_WORDS   = 1,
  parameter logic [BOOT_WORDS*(ADDR_W+DATA_W)-1:0] BOOT_TABLE = {3'd0, 16'h7cbc},
  parameter int unsigned MODE_WAIT    = 1023,
  parameter int unsigned DCM_EXT      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              mode_i,
  input  logic              ddrb_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] chan_sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              boot_done_o,
  output logic              mode_o,
  output logic              ddrb_o,
  output logic              dcm_reset_o,
  output logic              ctrl_clk_o,
  output logic              ctrl_data_o,
  output logic [NUM_CH-1:0] ctrl_strb_o
);

  localparam int unsigned W  = ADDR_W + DATA_W;
  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned KW = $clog2(BOOT_WORDS + 1);
  localparam int unsigned MW = $clog2(MODE_WAIT);
  localparam int unsigned EW = (DCM_EXT > 0) ? $clog2(DCM_EXT + 1) : 1;

  localparam logic [MW-1:0] MODE_LAST = MW'(MODE_WAIT - 1);
  localparam logic [MW-1:0] MODE_HALF = MW'(MODE_WAIT / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [KW-1:0] WORD_LAST = KW'(BOOT_WORDS - 1);
  localparam logic [EW-1:0] EXT_LOAD  = EW'(DCM_EXT);

  typedef enum logic [2:0] {
    T_IDLE, T_WAIT, T_STRB0, T_DATA, T_COMMIT, T_STRB1, T_SWAIT
  } xfer_state_t;

  typedef enum logic [2:0] {
    B_MODE_CLEAR, B_LOAD, B_XFER_WAIT, B_NEXT, B_RESET, B_DONE
  } boot_state_t;

  xfer_state_t             t_state, t_next;
  boot_state_t             b_state, b_next;
  logic [CLK_DIV_LOG2-1:0] div_cnt;
  logic                    tick;
  logic [W-1:0]            shift;
  logic [NUM_CH-1:0]       sel;
  logic [BW-1:0]           bit_cnt;
  logic                    load;
  logic [MW-1:0]           mode_cnt;
  logic [KW-1:0]           word_idx;
  logic [W-1:0]            boot_entry;
  logic [EW-1:0]           ext_cnt;
  logic                    host_own;
  logic                    mode_int, ddrb_int, start_int;
  logic                    ddrb_mux, start_mux;
  logic [W-1:0]            xfer_word;
  logic [NUM_CH-1:0]       xfer_sel;
  logic                    strb_win;

  // Serial clock divider
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + 1'b1;
  end

  assign tick = &div_cnt;

  // Source muxing: the host owns the path only once boot has completed
  assign boot_done_o = (b_state == B_DONE);
  assign host_own    = request && boot_done_o;
  assign mode_int    = !((b_state == B_MODE_CLEAR) && (mode_cnt < MODE_HALF));
  assign ddrb_int    = (b_state == B_RESET);
  assign start_int   = (b_state == B_LOAD);
  assign mode_o      = host_own ? mode_i  : mode_int;
  assign ddrb_mux    = host_own ? ddrb_i  : ddrb_int;
  assign start_mux   = host_own ? start_i : start_int;

  always_comb begin
    boot_entry = '0;
    for (int unsigned i = 0; i < BOOT_WORDS; i++) begin
      if (word_idx == KW'(i)) boot_entry = BOOT_TABLE[i*W +: W];
    end
  end

  assign xfer_word = host_own ? {addr_i, data_i} : boot_entry;
  assign xfer_sel  = host_own ? chan_sel_i : '1;

  // Transfer FSM
  always_comb begin
    t_next = t_state;
    load   = 1'b0;
    unique case (t_state)
      T_IDLE:   if (start_mux) begin t_next = T_WAIT; load = 1'b1; end
      T_WAIT:   if (tick) t_next = T_STRB0;
      T_STRB0:  if (tick) t_next = T_DATA;
      T_DATA:   if (tick && (bit_cnt == BIT_LAST)) t_next = T_COMMIT;
      T_COMMIT: if (tick) t_next = T_STRB1;
      T_STRB1:  if (tick) t_next = T_SWAIT;
      T_SWAIT:  if (tick) t_next = T_IDLE;
      default:  t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T_IDLE;
      shift   <= '0;
      sel     <= '0;
      bit_cnt <= '0;
      done_o  <= 1'b0;
    end else begin
      t_state <= t_next;
      done_o  <= (t_state == T_SWAIT) && tick;
      if (load) begin
        shift   <= xfer_word;
        sel     <= xfer_sel;
        bit_cnt <= '0;
      end else if ((t_state == T_DATA) && tick) begin
        shift   <= {shift[W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign busy_o      = (t_state != T_IDLE);
  assign strb_win    = (t_state == T_DATA) || (t_state == T_COMMIT);
  assign ctrl_strb_o = ~({NUM_CH{strb_win}} & sel);
  assign ctrl_data_o = shift[W-1];
  assign ctrl_clk_o  = ((t_state == T_IDLE) || (t_state == T_WAIT)) ? 1'b0
                                                                    : div_cnt[CLK_DIV_LOG2-1];

  // Boot FSM
  always_comb begin
    b_next = b_state;
    unique case (b_state)
      B_MODE_CLEAR: if (mode_cnt == MODE_LAST) b_next = B_LOAD;
      B_LOAD:       b_next = B_XFER_WAIT;
      B_XFER_WAIT:  if (!busy_o) b_next = B_NEXT;
      B_NEXT:       b_next = (word_idx == WORD_LAST) ? B_RESET : B_LOAD;
      B_RESET:      b_next = B_DONE;
      B_DONE:       b_next = B_DONE;
      default:      b_next = B_MODE_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_state  <= B_MODE_CLEAR;
      mode_cnt <= '0;
      word_idx <= '0;
    end else begin
      b_state <= b_next;
      if ((b_state == B_MODE_CLEAR) && (mode_cnt != MODE_LAST)) mode_cnt <= mode_cnt + 1'b1;
      if (b_state == B_NEXT) word_idx <= word_idx + 1'b1;
    end
  end

  // DCM reset extension restarts on every cycle the muxed ddrb is high
  always_ff @(posedge clk) begin
    if (rst) begin
      ddrb_o  <= 1'b0;
      ext_cnt <= '0;
    end else begin
      ddrb_o <= ddrb_mux;
      if (ddrb_mux)            ext_cnt <= EXT_LOAD;
      else if (ext_cnt != '0)  ext_cnt <= ext_cnt - 1'b1;
    end
  end

  assign dcm_reset_o = !boot_done_o || ddrb_mux || (ext_cnt != '0);

endmodule

// File: tb/tb_adc_config_seq.sv
// Scoreboard bench for adc_config_seq: expected frames are queued by the
// stimulus and compared by a pin-level monitor that decodes each strobed frame.
module tb_adc_config_seq;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned W      = ADDR_W + DATA_W;

  typedef struct packed {
    logic [NUM_CH-1:0] mask;
    logic [W-1:0]      word;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              request, mode_i, ddrb_i, start_i;
  logic [NUM_CH-1:0] chan_sel_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o, done_o, boot_done_o, mode_o, ddrb_o, dcm_reset_o;
  logic              ctrl_clk_o, ctrl_data_o;
  logic [NUM_CH-1:0] ctrl_strb_o;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     frames_done = 0;

  always #5 clk = ~clk;

  adc_config_seq #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CLK_DIV_LOG2(2),
    .BOOT_WORDS  (3),
    .BOOT_TABLE  ({3'd2, 16'h1234, 3'd1, 16'hABCD, 3'd0, 16'h7c2c}),
    .MODE_WAIT   (16),
    .DCM_EXT     (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .mode_i     (mode_i),
    .ddrb_i     (ddrb_i),
    .start_i    (start_i),
    .chan_sel_i (chan_sel_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .boot_done_o(boot_done_o),
    .mode_o     (mode_o),
    .ddrb_o     (ddrb_o),
    .dcm_reset_o(dcm_reset_o),
    .ctrl_clk_o (ctrl_clk_o),
    .ctrl_data_o(ctrl_data_o),
    .ctrl_strb_o(ctrl_strb_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [NUM_CH-1:0] mask, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    frame_t f;
    f.mask = mask;
    f.word = {a, d};
    exp_q.push_back(f);
  endtask

  task automatic push_boot;
    push_frame(2'b11, 3'd0, 16'h7c2c);
    push_frame(2'b11, 3'd1, 16'hABCD);
    push_frame(2'b11, 3'd2, 16'h1234);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy_o && n < bound);
    check(name, busy_o, 0);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!done_o && n < bound);
    check(name, done_o, 1);
  endtask

  // Monitor: decode frames on the pins, sampling on the falling clk edge
  initial begin : monitor
    logic          in_frame = 1'b0;
    logic          prev_clk = 1'b0;
    logic [W:0]    bits     = '0;
    logic [NUM_CH-1:0] mask_acc = '0;
    int            nbits    = 0;
    frame_t        f;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        nbits    = 0;
      end else if (ctrl_strb_o != '1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          nbits    = 0;
          bits     = '0;
          mask_acc = '0;
        end
        mask_acc = mask_acc | ~ctrl_strb_o;
        if (ctrl_clk_o && !prev_clk) begin
          bits = {bits[W-1:0], ctrl_data_o};
          nbits++;
        end
      end else if (in_frame) begin
        in_frame = 1'b0;
        frames_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got word 0x%0h with no frame expected", bits);
        end else begin
          f = exp_q.pop_front();
          check("frame_bits", nbits, W + 1);
          check("frame_word", bits, {f.word, 1'b0});
          check("frame_mask", mask_acc, f.mask);
        end
      end
      prev_clk = ctrl_clk_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, ddrb_cnt, ddrb_cyc, ddrb_frames, fall, hi, dones, frames_before;

    rst = 1'b1; request = 1'b1; mode_i = 1'b1; ddrb_i = 1'b0; start_i = 1'b1;
    chan_sel_i = 2'b01; addr_i = 3'd6; data_i = 16'h0F0F;
    push_boot();
    push_frame(2'b01, 3'd6, 16'h0F0F);  // host start held through boot is taken only after boot

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_boot_done", boot_done_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_ddrb", ddrb_o, 0);
    check("rst_dcm", dcm_reset_o, 1);
    check("rst_sclk", ctrl_clk_o, 0);
    check("rst_sdata", ctrl_data_o, 0);
    check("rst_strb", ctrl_strb_o, 2'b11);

    @(negedge clk) rst = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!mode_o && cyc < 100);
    check("mode_rise_cycles", cyc, 8);

    // Boot: three frames, one ddrb pulse, dcm released five cycles later
    cyc = 0; ddrb_cnt = 0; ddrb_cyc = -1; ddrb_frames = -1; fall = -1;
    while (fall < 0 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (ddrb_o) begin ddrb_cnt++; ddrb_cyc = cyc; ddrb_frames = frames_done; end
      if (boot_done_o && !dcm_reset_o) fall = cyc;
      if (boot_done_o && busy_o) start_i = 1'b0;
    end
    start_i = 1'b0;
    check("boot_done", boot_done_o, 1);
    check("boot_ddrb_pulses", ddrb_cnt, 1);
    check("boot_ddrb_after_frames", ddrb_frames, 3);
    check("boot_dcm_ext", fall - ddrb_cyc, 5);
    check("mode_host_high", mode_o, 1);
    mode_i = 1'b0; #1;
    check("mode_host_follow", mode_o, 0);
    mode_i = 1'b1;
    wait_idle("boot_host_idle", 400);

    // Host write to channel 1 only
    @(posedge clk); #1;
    chan_sel_i = 2'b10; addr_i = 3'd5; data_i = 16'h00FF; start_i = 1'b1;
    push_frame(2'b10, 3'd5, 16'h00FF);
    @(posedge clk); #1;
    start_i = 1'b0;
    check("host_busy", busy_o, 1);
    dones = 0;
    repeat (150) begin @(posedge clk); #1; if (done_o) dones++; end
    check("host_done_count", dones, 1);
    check("host_busy_after", busy_o, 0);

    // start held high, data changed while busy: one frame with the first data,
    // then a fresh frame only once IDLE is re-entered
    chan_sel_i = 2'b11; addr_i = 3'd3; data_i = 16'hA5A5; start_i = 1'b1;
    push_frame(2'b11, 3'd3, 16'hA5A5);
    push_frame(2'b11, 3'd3, 16'h5A5A);
    @(posedge clk); #1;
    check("hold_busy", busy_o, 1);
    data_i = 16'h5A5A;
    wait_done("hold_done1", 300);
    check("hold_idle_at_done", busy_o, 0);
    @(posedge clk); #1;
    check("hold_restart", busy_o, 1);
    start_i = 1'b0;
    wait_done("hold_done2", 300);
    repeat (10) @(posedge clk);
    #1;
    check("hold_no_third", busy_o, 0);

    // Host ddrb after boot
    ddrb_i = 1'b1; #1;
    check("host_dcm_comb", dcm_reset_o, 1);
    @(posedge clk); #1;
    check("host_ddrb_o", ddrb_o, 1);
    ddrb_i = 1'b0;
    hi = dcm_reset_o ? 1 : 0;
    @(posedge clk); #1;
    check("host_ddrb_o_low", ddrb_o, 0);
    if (dcm_reset_o) hi++;
    repeat (8) begin @(posedge clk); #1; if (dcm_reset_o) hi++; end
    check("host_dcm_ext", hi, 5);

    // Reset in the middle of DATA
    frames_before = frames_done;
    chan_sel_i = 2'b11; addr_i = 3'd7; data_i = 16'hFFFF; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (ctrl_strb_o == 2'b11 && cyc < 100);
    check("abort_strb_low", ctrl_strb_o, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_strb", ctrl_strb_o, 2'b11);
    check("abort_busy", busy_o, 0);
    check("abort_boot_done", boot_done_o, 0);
    check("abort_dcm", dcm_reset_o, 1);
    repeat (2) @(posedge clk);
    request = 1'b0;
    push_boot();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("reboot_mode", mode_o, 0);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!boot_done_o && cyc < 3000);
    check("reboot_done", boot_done_o, 1);
    check("reboot_frames", frames_done - frames_before, 3);
    check("reboot_mode_idle", mode_o, 1);
    repeat (20) @(posedge clk);
    #1;
    check("reboot_no_start", busy_o, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_config_seq.md
Name: adc_config_seq

Overview:
- Parametrised three-wire serial configuration controller for one or more ADCs sharing serial clock and data lines, with one active-low strobe per channel.
- After reset it runs an autonomous boot sequence: mode-pin settle, a table of BOOT_WORDS config words broadcast to every channel, then a DDR/DCM reset pulse.
- After boot, software-side logic takes over through a request/start/busy/done handshake with per-channel select.
- Sits between the OPB register file and the ADC pads.

Parameters:
NUM_CH, 2, number of ADC channels (strobe outputs)
ADDR_W, 3, serial address field width
DATA_W, 16, serial data field width
CLK_DIV_LOG2, 7, serial clock period = 2^CLK_DIV_LOG2 clk cycles
BOOT_WORDS, 1, number of boot table entries (>=1)
BOOT_TABLE, {3'd0,16'h7cbc}, BOOT_WORDS*(ADDR_W+DATA_W) bits, entry 0 in LSBs, each entry {addr,data}
MODE_WAIT, 1023, mode settle cycles (>=2)
DCM_EXT, 5, dcm reset extension cycles after a ddrb pulse

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
request  in  1  host owns mode/ddrb/start path (ignored until boot_done_o)
mode_i  in  1  host mode level
ddrb_i  in  1  host ddrb level
start_i  in  1  host transfer start (level-sampled)
chan_sel_i  in  NUM_CH  host channel select mask
addr_i  in  ADDR_W  host address
data_i  in  DATA_W  host data
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse when a transfer returns to idle
boot_done_o  out  1  boot sequence complete
mode_o  out  1  ADC mode pin
ddrb_o  out  1  ADC DDR reset, registered
dcm_reset_o  out  1  DCM reset
ctrl_clk_o  out  1  serial clock
ctrl_data_o  out  1  serial data, MSB first
ctrl_strb_o  out  NUM_CH  active-low strobes

Behaviour:
- Reset values:
  - busy_o=0, done_o=0, boot_done_o=0, mode_o=0, ddrb_o=0, dcm_reset_o=1.
  - ctrl_clk_o=0, ctrl_data_o=0, ctrl_strb_o=all 1.
  - Divider counter=0.
- Reset mid-transfer aborts immediately and restarts boot.
- Divider: free-running CLK_DIV_LOG2-bit counter, wraps at all-ones. "tick" = counter all-ones.
- Transfer FSM (W=ADDR_W+DATA_W): IDLE, WAIT, STRB0, DATA, COMMIT, STRB1, SWAIT.
  - In IDLE, an accepted start loads shift={addr,data}, latches sel, bit count=0, and moves to WAIT on the same edge. This is not tick-gated.
  - On each tick:
    - WAIT→STRB0, STRB0→DATA.
    - DATA: shift left with 0 fill, count+1; after W ticks in DATA → COMMIT.
    - COMMIT→STRB1→SWAIT→IDLE.
  - done_o pulses on the SWAIT→IDLE edge.
- Outputs:
  - busy_o = state!=IDLE.
  - ctrl_clk_o = 0 in IDLE/WAIT, else counter MSB.
  - ctrl_data_o = shift MSB.
  - ctrl_strb_o[i] = !((DATA or COMMIT) and sel[i]).
  - A sel of all zeros still clocks the full frame, with no strobe asserted.
- A start while busy is ignored, not queued. Host start is accepted only when request=1 and boot_done_o=1.
- Boot FSM: MODE_CLEAR, LOAD, XFER_WAIT, NEXT, RESET, DONE.
  - MODE_CLEAR: counts MODE_WAIT cycles. mode_o=0 for the first half (floor(MODE_WAIT/2) cycles), then 1.
  - LOAD: issues an internal start of table entry k with sel=all ones.
  - XFER_WAIT: waits for !busy.
  - NEXT: k+1; returns to LOAD if k<BOOT_WORDS, else goes to RESET.
  - RESET: internal ddrb=1 for exactly one cycle.
  - DONE: terminal. boot_done_o=1 from DONE.
- Muxing:
  - Internal sources drive mode/ddrb/start when request=0 or boot incomplete.
  - After boot with request=0, internal start=0 and mode holds 1.
- ddrb_o is a one-cycle registered copy of the muxed ddrb.
- dcm_reset_o:
  - =1 whenever boot is not in DONE.
  - In DONE, =1 for DCM_EXT cycles after the last cycle muxed ddrb was high, then 0.
  - Extension restarts on every ddrb high cycle.
- Frame length: W+5 ticks after WAIT entry, plus up to 2^CLK_DIV_LOG2-1 alignment cycles.

Test Plan:
- Boot, defaults with CLK_DIV_LOG2=2, MODE_WAIT=16: mode_o rises after 8 cycles; all strobes go low together for 20 ticks (19 DATA+1 COMMIT); sampling ctrl_data_o on ctrl_clk_o rising yields 0x07cbc; ddrb_o high 1 cycle; boot_done_o=1; dcm_reset_o falls 5 cycles after ddrb.
- BOOT_WORDS=3, BOOT_TABLE={(2,0x1234),(1,0xABCD),(0,0x7c2c)}: three frames in entry order 0,1,2; the single ddrb pulse comes only after the third frame.
- Host write, request=1, chan_sel=2'b10, addr=5, data=0x00FF: only ctrl_strb_o[1] asserts; serial bits = 101 0000000011111111; done_o pulses once; busy_o low afterwards.
- start_i held high through a whole frame, plus a second start while busy with different data: exactly one frame, carrying the first data; a new frame starts only after IDLE is re-entered.
- request=1 during boot with start_i=1: ignored until boot_done_o; host ddrb_i=1 after boot → ddrb_o high next cycle and dcm_reset_o extended by DCM_EXT.
- rst asserted mid-DATA: strobes return to 1 the next cycle; boot restarts with mode_o=0 and the full table re-sent.
